ftdi_tx_packetizer: RTL and testbench

FTDI_TX_PACKETIZER -- requirements
Module: ftdi_tx_packetizer

---
 rtl/ftdi_tx_packetizer.sv | 124 ++++++++++++
 tb/tb_ftdi_tx_packetizer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_packetizer.sv
// rtl/ftdi_tx_packetizer.sv - frames 24-bit DMM samples as A5,B2,B1,B0,CSUM bytes into a circular byte buffer
module ftdi_tx_packetizer #(
    parameter int pDataWidth = 8,
    parameter int pDepth     = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [23:0]           iSample,
    input  logic                  iSampleValid,
    output logic                  oSampleReady,
    output logic [pDataWidth-1:0] oRamRdData,
    output logic                  oPacketAvail,
    input  logic                  iPacketRead,
    output logic                  oOverflow
);

    localparam int AW = $clog2(pDepth);

    typedef enum logic [2:0] {IDLE, HDR, B2, B1, B0, CSUM} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [23:0]             sample_q;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           wr_ptr_next;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           rd_ptr_next;
    logic [AW:0]             count;
    logic [AW:0]             count_next;
    logic [pDataWidth-1:0]   mem [pDepth];
    logic                    accept;
    logic                    wr_en;
    logic                    rd_en;
    logic                    ready_next;
    logic [7:0]              wr_byte;
    logic [pDataWidth-1:0]   wr_data;
    logic [pDataWidth-1:0]   rd_data_next;

    assign accept = iSampleValid & oSampleReady;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_byte    = 8'h00;
        case (state)
            IDLE: if (accept) state_next = HDR;
            HDR: begin
                wr_en      = 1'b1;
                wr_byte    = 8'hA5;
                state_next = B2;
            end
            B2: begin
                wr_en      = 1'b1;
                wr_byte    = sample_q[23:16];
                state_next = B1;
            end
            B1: begin
                wr_en      = 1'b1;
                wr_byte    = sample_q[15:8];
                state_next = B0;
            end
            B0: begin
                wr_en      = 1'b1;
                wr_byte    = sample_q[7:0];
                state_next = CSUM;
            end
            CSUM: begin
                wr_en      = 1'b1;
                wr_byte    = sample_q[23:16] + sample_q[15:8] + sample_q[7:0];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en       = iPacketRead && (count != '0);
        wr_data     = pDataWidth'(wr_byte);
        wr_ptr_next = wr_ptr + AW'(wr_en);
        rd_ptr_next = rd_ptr + AW'(rd_en);
        case ({wr_en, rd_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        // Accept only when the whole 5-byte frame is guaranteed to fit.
        ready_next = (state_next == IDLE) &&
                     ((32'(count_next) + 32'd5) <= 32'(pDepth));
        // A byte written straight into the next head slot must not be missed.
        if (wr_en && (wr_ptr == rd_ptr_next))
            rd_data_next = wr_data;
        else
            rd_data_next = mem[rd_ptr_next];
    end

    always_ff @(posedge iClk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state        <= IDLE;
            sample_q     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            oRamRdData   <= '0;
            oPacketAvail <= 1'b0;
            oSampleReady <= 1'b0;
            oOverflow    <= 1'b0;
        end else begin
            state        <= state_next;
            if (accept) sample_q <= iSample;
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            oRamRdData   <= rd_data_next;
            oPacketAvail <= (count_next != '0);
            oSampleReady <= ready_next;
            if (iSampleValid && !oSampleReady) oOverflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ftdi_tx_packetizer.sv
// tb/tb_ftdi_tx_packetizer.sv - directed self-checking bench for ftdi_tx_packetizer
module tb_ftdi_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [7:0]  ram_rd_data;
    logic        packet_avail;
    logic        packet_read = 1'b0;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    ftdi_tx_packetizer #(.pDataWidth(8), .pDepth(16)) dut (
        .iClk         (clk),
        .iRst         (rst),
        .iSample      (sample),
        .iSampleValid (sample_valid),
        .oSampleReady (sample_ready),
        .oRamRdData   (ram_rd_data),
        .oPacketAvail (packet_avail),
        .iPacketRead  (packet_read),
        .oOverflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] csum(input logic [23:0] s);
        return s[23:16] + s[15:8] + s[7:0];
    endfunction

    // Waits (bounded) for ready, offers one sample for one cycle; returns at the negedge after acceptance.
    task automatic send_sample(input logic [23:0] s, output bit ok, output int acc_cyc);
        int w = 0;
        while (sample_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = (sample_ready === 1'b1);
        acc_cyc = cyc;
        sample = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", sample_ready); else pass_cnt++;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL reset_avail: got %b want 0", packet_avail); else pass_cnt++;
        total_cnt++; if (ram_rd_data !== 8'h00) $display("FAIL reset_data: got %h want 00", ram_rd_data); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (sample_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", sample_ready); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        sample = 24'h123456;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL frame_busy_ready: got %b want 0", sample_ready); else pass_cnt++;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL frame_avail_early: got %b want 0", packet_avail); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (packet_avail !== 1'b1) $display("FAIL frame_avail_hdr: got %b want 1", packet_avail); else pass_cnt++;
        total_cnt++; if (ram_rd_data !== 8'hA5) $display("FAIL frame_hdr_data: got %h want a5", ram_rd_data); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (ram_rd_data !== 8'hA5) $display("FAIL frame_head_hold: got %h want a5", ram_rd_data); else pass_cnt++;
        total_cnt++; if (sample_ready !== 1'b1) $display("FAIL frame_ready_back: got %b want 1", sample_ready); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL frame_ovf: got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_drain();
        logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h9C};
        packet_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++; if (ram_rd_data !== exp[i]) $display("FAIL drain_byte%0d: got %h want %h", i, ram_rd_data, exp[i]); else pass_cnt++;
            total_cnt++; if (packet_avail !== 1'b1) $display("FAIL drain_avail%0d: got %b want 1", i, packet_avail); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL drain_empty: got %b want 0", packet_avail); else pass_cnt++;
        // Extra read while empty must be ignored; later tests depend on pointer alignment.
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL drain_empty_read: got %b want 0", packet_avail); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [7:0] fb [15] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06,
                                8'hA5, 8'hA0, 8'hB0, 8'hC0, 8'h10,
                                8'hA5, 8'h7F, 8'h80, 8'h81, 8'h80};
        logic [23:0] s [3] = '{24'h010203, 24'hA0B0C0, 24'h7F8081};
        bit ok;
        int ac;
        for (int f = 0; f < 3; f++) begin
            send_sample(s[f], ok, ac);
            total_cnt++; if (ok !== 1'b1) $display("FAIL full_send%0d: ready timeout", f); else pass_cnt++;
        end
        repeat (5) @(negedge clk);
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", sample_ready); else pass_cnt++;
        total_cnt++; if (ram_rd_data !== 8'hA5) $display("FAIL full_head: got %h want a5", ram_rd_data); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL full_ovf_pre: got %b want 0", overflow); else pass_cnt++;
        sample = 24'hDEADBE;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL full_ovf_set: got %b want 1", overflow); else pass_cnt++;
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL full_reject: got %b want 0", sample_ready); else pass_cnt++;
        packet_read = 1'b1;
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (ram_rd_data !== fb[1]) $display("FAIL full_read1: got %h want %h", ram_rd_data, fb[1]); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL full_free2_ready: got %b want 0", sample_ready); else pass_cnt++;
        packet_read = 1'b1;
        for (int i = 2; i < 15; i++) begin
            @(negedge clk);
            total_cnt++; if (ram_rd_data !== fb[i]) $display("FAIL full_byte%0d: got %h want %h", i, ram_rd_data, fb[i]); else pass_cnt++;
        end
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL full_empty: got %b want 0", packet_avail); else pass_cnt++;
        total_cnt++; if (sample_ready !== 1'b1) $display("FAIL full_ready_after: got %b want 1", sample_ready); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL full_ovf_sticky: got %b want 1", overflow); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] rest [3] = '{8'h0B, 8'h0C, 8'h21};
        bit ok;
        int ac;
        send_sample(24'h0A0B0C, ok, ac);
        total_cnt++; if (ok !== 1'b1) $display("FAIL simul_send: ready timeout"); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ram_rd_data !== 8'hA5) $display("FAIL simul_head: got %h want a5", ram_rd_data); else pass_cnt++;
        packet_read = 1'b1;
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (ram_rd_data !== 8'h0A) $display("FAIL simul_bypass: got %h want 0a", ram_rd_data); else pass_cnt++;
        total_cnt++; if (packet_avail !== 1'b1) $display("FAIL simul_avail: got %b want 1", packet_avail); else pass_cnt++;
        repeat (3) @(negedge clk);
        packet_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (ram_rd_data !== rest[i]) $display("FAIL simul_byte%0d: got %h want %h", i, ram_rd_data, rest[i]); else pass_cnt++;
            total_cnt++; if (packet_avail !== 1'b1) $display("FAIL simul_avail%0d: got %b want 1", i, packet_avail); else pass_cnt++;
        end
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL simul_empty: got %b want 0", packet_avail); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [23:0] s [10] = '{24'h123456, 24'hFFFFFF, 24'h000000, 24'h010101, 24'h800080,
                                24'hABCDEF, 24'h55AA55, 24'h0F0F0F, 24'hFF0001, 24'h7E7E7E};
        logic [7:0] exp [50];
        logic [7:0] rx [64];
        int acc [10];
        int rx_n = 0;
        bit ok_all = 1'b1;
        for (int f = 0; f < 10; f++) begin
            exp[f*5]   = 8'hA5;
            exp[f*5+1] = s[f][23:16];
            exp[f*5+2] = s[f][15:8];
            exp[f*5+3] = s[f][7:0];
            exp[f*5+4] = csum(s[f]);
        end
        packet_read = 1'b1;
        fork
            begin
                bit ok;
                for (int f = 0; f < 10; f++) begin
                    send_sample(s[f], ok, acc[f]);
                    if (!ok) ok_all = 1'b0;
                end
            end
            begin
                repeat (80) begin
                    @(negedge clk);
                    if (packet_avail === 1'b1 && rx_n < 64) begin
                        rx[rx_n] = ram_rd_data;
                        rx_n++;
                    end
                end
            end
        join
        packet_read = 1'b0;
        total_cnt++; if (ok_all !== 1'b1) $display("FAIL wrap_send: ready timeout"); else pass_cnt++;
        total_cnt++; if (rx_n != 50) $display("FAIL wrap_count: got %0d want 50", rx_n); else pass_cnt++;
        for (int i = 0; i < 50; i++) begin
            total_cnt++; if (i >= rx_n || rx[i] !== exp[i]) $display("FAIL wrap_byte%0d: got %h want %h", i, (i < rx_n) ? rx[i] : 8'hxx, exp[i]); else pass_cnt++;
        end
        total_cnt++; if (rx[9] !== 8'hFD) $display("FAIL wrap_csum_ffffff: got %h want fd", rx[9]); else pass_cnt++;
        for (int f = 0; f < 9; f++) begin
            total_cnt++; if (acc[f+1] - acc[f] != 6) $display("FAIL wrap_spacing%0d: got %0d want 6", f, acc[f+1] - acc[f]); else pass_cnt++;
        end
        total_cnt++; if (overflow !== 1'b1) $display("FAIL wrap_ovf_sticky: got %b want 1", overflow); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h06};
        bit ok;
        int ac;
        send_sample(24'h445566, ok, ac);
        total_cnt++; if (ok !== 1'b1) $display("FAIL mid_send: ready timeout"); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (packet_avail !== 1'b1) $display("FAIL mid_avail_pre: got %b want 1", packet_avail); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL mid_rst_avail: got %b want 0", packet_avail); else pass_cnt++;
        total_cnt++; if (ram_rd_data !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", ram_rd_data); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf: got %b want 0", overflow); else pass_cnt++;
        total_cnt++; if (sample_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", sample_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (sample_ready !== 1'b1) $display("FAIL mid_release_ready: got %b want 1", sample_ready); else pass_cnt++;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL mid_release_avail: got %b want 0", packet_avail); else pass_cnt++;
        send_sample(24'h010203, ok, ac);
        @(negedge clk);
        total_cnt++; if (ram_rd_data !== 8'hA5) $display("FAIL mid_new_hdr: got %h want a5", ram_rd_data); else pass_cnt++;
        repeat (4) @(negedge clk);
        packet_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++; if (ram_rd_data !== exp[i]) $display("FAIL mid_byte%0d: got %h want %h", i, ram_rd_data, exp[i]); else pass_cnt++;
        end
        @(negedge clk);
        packet_read = 1'b0;
        total_cnt++; if (packet_avail !== 1'b0) $display("FAIL mid_empty: got %b want 0", packet_avail); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_drain();
        test_full();
        test_simultaneous();
        test_wrap();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
